// File: rtl/alu_pkg.sv
// Shared types and elaboration helpers for the ALU add/subtract datapath.
// Opcode encoding matches the i_op field driven by the ALU operand registers.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } addsub_op_t;

    // Pipeline depth: one lookahead group is resolved per stage.
    function automatic int calc_nstg(input int bits, input int group);
        return bits / group;
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead group; all internal carries are
// expanded directly from generate/propagate terms and the group carry-in.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [GROUP-1:0] gen;
    logic [GROUP-1:0] prop;
    logic [GROUP:0]   carry;
    logic             prod;

    always_comb begin
        gen      = a & b;
        prop     = a ^ b;
        carry    = '0;
        prod     = 1'b0;
        carry[0] = cin;
        // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, built as a flat sum of products
        for (int i = 0; i < GROUP; i++) begin
            carry[i+1] = gen[i];
            prod       = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry[i+1] = carry[i+1] | (prod & gen[j]);
                prod       = prod & prop[j];
            end
            carry[i+1] = carry[i+1] | (prod & cin);
        end
        sum      = prop ^ carry[GROUP-1:0];
        cout     = carry[GROUP];
        c_msb_in = carry[GROUP-1];
    end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined add/subtract: one lookahead group per stage, operands skewed forward
// and partial results de-skewed so the whole word leaves the last stage together.
module pipelined_cla_addsub
    import alu_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int GROUP = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    input  logic [1:0]      i_op,
    input  logic            i_carry,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [BITS-1:0] o_result,
    output logic            o_cout,
    output logic            o_ovf,
    output logic            o_zero,
    output logic            o_neg
);

    localparam int NSTG = calc_nstg(BITS, GROUP);

    addsub_op_t      op;
    logic [BITS-1:0] b_eff;
    logic            cin;
    logic            en;

    always_comb begin
        op    = addsub_op_t'(i_op);
        b_eff = i_b;
        cin   = 1'b0;
        case (op)
            OP_ADD: cin = 1'b0;
            OP_SUB: begin
                b_eff = ~i_b;
                cin   = 1'b1;
            end
            OP_ADC: cin = i_carry;
            OP_SBB: begin
                b_eff = ~i_b;
                cin   = ~i_carry;
            end
            default: cin = 1'b0;
        endcase
    end

    // Single enable for every stage: bubbles are never squeezed out.
    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LO = k * GROUP;
        localparam int HI = LO + GROUP;

        logic [BITS-LO-1:0] op_a;
        logic [BITS-LO-1:0] op_b;
        logic               c_in;
        logic               v_in;
        logic [GROUP-1:0]   grp_sum;
        logic               grp_cout;
        logic               grp_cmsb;
        logic [HI-1:0]      res_nxt;
        logic [HI-1:0]      res_d;
        logic [HI-1:0]      res_q;
        logic               valid_d;
        logic               valid_q;
        logic               carry_d;
        logic               carry_q;

        if (k == 0) begin : g_src
            assign op_a    = i_a;
            assign op_b    = b_eff;
            assign c_in    = cin;
            assign v_in    = i_valid;
            assign res_nxt = grp_sum;
        end else begin : g_src
            assign op_a    = g_stg[k-1].g_skew.a_q;
            assign op_b    = g_stg[k-1].g_skew.b_q;
            assign c_in    = g_stg[k-1].carry_q;
            assign v_in    = g_stg[k-1].valid_q;
            assign res_nxt = {grp_sum, g_stg[k-1].res_q};
        end

        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .a        (op_a[GROUP-1:0]),
            .b        (op_b[GROUP-1:0]),
            .cin      (c_in),
            .sum      (grp_sum),
            .cout     (grp_cout),
            .c_msb_in (grp_cmsb)
        );

        always_comb begin
            valid_d = valid_q;
            carry_d = carry_q;
            res_d   = res_q;
            if (en) begin
                valid_d = v_in;
                carry_d = grp_cout;
                res_d   = res_nxt;
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                res_q   <= res_d;
            end
        end

        // Operand groups not yet consumed ride forward to the later stages.
        if (k < NSTG - 1) begin : g_skew
            logic [BITS-HI-1:0] a_d;
            logic [BITS-HI-1:0] a_q;
            logic [BITS-HI-1:0] b_d;
            logic [BITS-HI-1:0] b_q;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (en) begin
                    a_d = op_a[BITS-LO-1:GROUP];
                    b_d = op_b[BITS-LO-1:GROUP];
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == NSTG - 1) begin : g_flags
            logic ovf_d;
            logic ovf_q;
            logic zero_d;
            logic zero_q;
            logic neg_d;
            logic neg_q;

            always_comb begin
                ovf_d  = ovf_q;
                zero_d = zero_q;
                neg_d  = neg_q;
                if (en) begin
                    ovf_d  = grp_cout ^ grp_cmsb;
                    zero_d = (res_nxt == '0);
                    neg_d  = res_nxt[BITS-1];
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                    neg_q  <= 1'b0;
                end else begin
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                    neg_q  <= neg_d;
                end
            end
        end
    end

    assign o_valid  = g_stg[NSTG-1].valid_q;
    assign o_result = g_stg[NSTG-1].res_q;
    assign o_cout   = g_stg[NSTG-1].carry_q;
    assign o_ovf    = g_stg[NSTG-1].g_flags.ovf_q;
    assign o_zero   = g_stg[NSTG-1].g_flags.zero_q;
    assign o_neg    = g_stg[NSTG-1].g_flags.neg_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: three configurations (8/4, 16/4, 8/8) share one
// stimulus stream; each keeps its own scoreboard of expected results.
module tb_pipelined_cla_addsub;

    typedef struct packed {
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
        logic [15:0] res;
    } exp_t;

    logic        clk;
    logic        drv_rst;
    logic        drv_valid;
    logic        drv_ready;
    logic [15:0] drv_a;
    logic [15:0] drv_b;
    logic [1:0]  drv_op;
    logic        drv_c;

    wire [2:0]   rdy_v;
    wire [2:0]   ov_v;
    wire [2:0]   cout_v;
    wire [2:0]   ovf_v;
    wire [2:0]   zero_v;
    wire [2:0]   neg_v;
    wire [7:0]   res0;
    wire [15:0]  res1;
    wire [7:0]   res2;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb [3][$];
    exp_t held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipelined_cla_addsub #(.BITS(8), .GROUP(4)) dut0 (
        .i_clk(clk), .i_reset(drv_rst), .i_valid(drv_valid), .o_ready(rdy_v[0]),
        .i_a(drv_a[7:0]), .i_b(drv_b[7:0]), .i_op(drv_op), .i_carry(drv_c),
        .o_valid(ov_v[0]), .i_ready(drv_ready), .o_result(res0), .o_cout(cout_v[0]),
        .o_ovf(ovf_v[0]), .o_zero(zero_v[0]), .o_neg(neg_v[0])
    );

    pipelined_cla_addsub #(.BITS(16), .GROUP(4)) dut1 (
        .i_clk(clk), .i_reset(drv_rst), .i_valid(drv_valid), .o_ready(rdy_v[1]),
        .i_a(drv_a), .i_b(drv_b), .i_op(drv_op), .i_carry(drv_c),
        .o_valid(ov_v[1]), .i_ready(drv_ready), .o_result(res1), .o_cout(cout_v[1]),
        .o_ovf(ovf_v[1]), .o_zero(zero_v[1]), .o_neg(neg_v[1])
    );

    pipelined_cla_addsub #(.BITS(8), .GROUP(8)) dut2 (
        .i_clk(clk), .i_reset(drv_rst), .i_valid(drv_valid), .o_ready(rdy_v[2]),
        .i_a(drv_a[7:0]), .i_b(drv_b[7:0]), .i_op(drv_op), .i_carry(drv_c),
        .o_valid(ov_v[2]), .i_ready(drv_ready), .o_result(res2), .o_cout(cout_v[2]),
        .o_ovf(ovf_v[2]), .o_zero(zero_v[2]), .o_neg(neg_v[2])
    );

    function automatic int wid(input int d);
        return (d == 1) ? 16 : 8;
    endfunction

    // Reference: plain integer arithmetic, overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic [1:0] op, input logic ci);
        logic [16:0] mask;
        logic [16:0] aa;
        logic [16:0] bb;
        logic [16:0] s;
        logic        c;
        exp_t        r;
        mask = (17'h1 << w) - 17'h1;
        aa   = {1'b0, a} & mask;
        bb   = (op[0] ? ~{1'b0, b} : {1'b0, b}) & mask;
        case (op)
            2'b00:   c = 1'b0;
            2'b01:   c = 1'b1;
            2'b10:   c = ci;
            default: c = ~ci;
        endcase
        s      = aa + bb + {16'h0, c};
        r.res  = s[15:0] & mask[15:0];
        r.cout = s[w];
        r.neg  = s[w-1];
        r.zero = (r.res == 16'h0);
        r.ovf  = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return r;
    endfunction

    function automatic exp_t obs_of(input int d);
        exp_t r;
        r.cout = cout_v[d];
        r.ovf  = ovf_v[d];
        r.zero = zero_v[d];
        r.neg  = neg_v[d];
        case (d)
            0:       r.res = {8'h00, res0};
            1:       r.res = res1;
            default: r.res = {8'h00, res2};
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: handoff and accept are both decided by values stable at the negedge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (drv_rst) begin
            for (int d = 0; d < 3; d++) sb[d].delete();
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (ov_v[d] && drv_ready) begin
                    n_assert++;
                    assert (sb[d].size() > 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_out dut%0d: observed %h expected none", d, obs_of(d));
                    end
                    if (sb[d].size() > 0) begin
                        e = sb[d].pop_front();
                        n_assert++;
                        assert (obs_of(d) === e) else begin
                            n_fail++;
                            $error("FAIL result dut%0d: observed %h expected %h", d, obs_of(d), e);
                        end
                    end
                end
                if (drv_valid && rdy_v[d])
                    sb[d].push_back(model(wid(d), drv_a, drv_b, drv_op, drv_c));
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input logic c);
        logic ok;
        ok        = 1'b0;
        drv_a     = a;
        drv_b     = b;
        drv_op    = op;
        drv_c     = c;
        drv_valid = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = rdy_v[0];
        end
        @(posedge clk);
        #1;
        chk("send_accept", {31'h0, ok}, 32'h1);
    endtask

    task automatic one_beat(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] op, input logic c, input exp_t e);
        send(a, b, op, c);
        drv_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, {31'h0, ov_v[0]}, 32'h1);
        chk(tag, {12'h0, obs_of(0)}, {12'h0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drv_valid = 1'b0;
        drv_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk("drain_empty", sb[d].size(), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] lat_exp;
        drv_rst   = 1'b1;
        drv_valid = 1'b0;
        drv_ready = 1'b1;
        drv_a     = 16'h0;
        drv_b     = 16'h0;
        drv_op    = 2'b00;
        drv_c     = 1'b0;
        repeat (3) @(posedge clk);
        #1 drv_rst = 1'b0;

        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("reset_out", {12'h0, obs_of(d)}, 32'h0);
        chk("reset_ovalid", {29'h0, ov_v}, 32'h0);
        chk("reset_ready", {29'h0, rdy_v}, 32'h7);

        // Latency 2 / 4 / 1 for the three configurations.
        @(posedge clk);
        #1;
        drv_a = 16'h000F; drv_b = 16'h0001; drv_op = 2'b00; drv_c = 1'b0; drv_valid = 1'b1;
        @(posedge clk);
        #1 drv_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lat_exp = {(i == 0), (i == 3), (i == 1)};
            chk("latency", {29'h0, ov_v}, {29'h0, lat_exp});
            if (i == 1) chk("add_0f_01", {12'h0, obs_of(0)}, 32'h00010);
        end
        drain();

        one_beat("sub_80_01", 16'h0080, 16'h0001, 2'b01, 1'b0, {4'b1100, 16'h007F});
        one_beat("sub_05_05", 16'h0005, 16'h0005, 2'b01, 1'b0, {4'b1010, 16'h0000});
        one_beat("adc_ff_00", 16'h00FF, 16'h0000, 2'b10, 1'b1, {4'b1010, 16'h0000});
        one_beat("sbb_10_01", 16'h0010, 16'h0001, 2'b11, 1'b1, {4'b1000, 16'h000E});
        one_beat("ripple_ff", 16'h00FF, 16'h0001, 2'b00, 1'b0, {4'b1010, 16'h0000});
        one_beat("neg_res",   16'h0001, 16'h0003, 2'b01, 1'b0, {4'b0001, 16'h00FE});
        drain();

        // Back-to-back stream with a 3-cycle output stall after beat 4.
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                drv_ready = 1'b0;
                drv_a = 16'h0005; drv_b = 16'h0001; drv_op = 2'b00; drv_c = 1'b0;
                drv_valid = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("stall_ready", {31'h0, rdy_v[0]}, 32'h0);
                    chk("stall_ovalid", {31'h0, ov_v[0]}, 32'h1);
                    if (s == 0) held = obs_of(0);
                    else chk("stall_hold", {12'h0, obs_of(0)}, {12'h0, held});
                end
                @(posedge clk);
                #1 drv_ready = 1'b1;
            end
            send(16'(i), 16'h0001, 2'b00, 1'b0);
        end
        drain();

        // Reset with beats in flight: nothing may emerge afterwards.
        send(16'h0033, 16'h0011, 2'b00, 1'b0);
        send(16'h0044, 16'h0022, 2'b01, 1'b0);
        drv_valid = 1'b0;
        drv_rst   = 1'b1;
        @(posedge clk);
        #1 drv_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_flush", {29'h0, ov_v}, 32'h0);
        end
        one_beat("post_reset", 16'h0012, 16'h0034, 2'b00, 1'b0, {4'b0000, 16'h0046});
        drain();

        // Random operands, ops, valid gaps and downstream stalls.
        for (int i = 0; i < 400; i++) begin
            drv_valid = ($urandom_range(0, 3) != 0);
            drv_ready = ($urandom_range(0, 3) != 0);
            drv_a     = 16'($urandom);
            drv_b     = 16'($urandom);
            drv_op    = 2'($urandom_range(0, 3));
            drv_c     = 1'($urandom_range(0, 1));
            if (i % 16 == 0) begin
                drv_a  = 16'hFFFF;
                drv_b  = 16'h0001;
                drv_op = 2'b00;
            end
            @(posedge clk);
            #1;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined successor to the combinational 8-bit carry-lookahead adder in the ALU datapath.
- Splits operands into lookahead groups and resolves one group per pipeline stage.
- Supports add, subtract, add-with-carry and subtract-with-borrow.
- Uses a valid/ready handshake with full backpressure and produces carry, overflow, zero and negative flags. Sits between the ALU operand registers and the result/flag writeback.

Parameters:
- BITS, 8, operand/result width; must be a multiple of GROUP.
- GROUP, 4, lookahead group width. NSTG = BITS/GROUP is the pipeline depth (1..BITS).

Ports:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  operand beat valid.
- o_ready  out  1  block can accept a beat this cycle.
- i_a  in  BITS  operand A.
- i_b  in  BITS  operand B.
- i_op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBB.
- i_carry  in  1  carry/borrow-in; used only for ADC/SBB.
- o_valid  out  1  result beat valid.
- i_ready  in  1  downstream accepts the result.
- o_result  out  BITS  sum/difference.
- o_cout  out  1  carry-out of MSB. For SUB/SBB it is the carry, i.e. 1 means no borrow.
- o_ovf  out  1  signed overflow.
- o_zero  out  1  o_result == 0.
- o_neg  out  1  o_result[BITS-1].

Behaviour:
- Operand prep at input:
  - b_eff = i_b inverted for SUB/SBB.
  - cin = 0 for ADD, 1 for SUB, i_carry for ADC, ~i_carry for SBB. SBB computes A-B-borrow.
- Stage k (0..NSTG-1):
  - Computes result bits [k*GROUP +: GROUP] from registered group operands and the carry registered from stage k-1.
  - Stage 0 uses cin.
  - Upper operand groups travel forward in skew registers; lower result groups travel forward in de-skew registers.
- Latency: a beat accepted at edge t appears on o_valid/o_result after edge t+NSTG-1. For NSTG=1 it is registered once.
- Throughput: one beat per cycle when i_ready=1.
- Handshake:
  - Global stage enable en = !o_valid | i_ready; o_ready = en. The whole pipeline advances together.
  - A beat is accepted iff i_valid & o_ready; otherwise a bubble enters stage 0.
  - o_valid/o_result/flags hold stable while o_valid=1 and i_ready=0.
  - Bubbles do not compress, which keeps the design simple.
  - Simultaneous output handoff and input accept in the same cycle is legal and required.
- Flags are computed in the last stage from the final result and carries:
  - ovf = c[BITS] ^ c[BITS-1].
  - zero is true only when the full result, including all de-skewed groups, is 0.
  - neg = MSB.
- Reset:
  - All valid bits clear; o_valid=0, o_result=0, o_cout=0, o_ovf=0, o_zero=0, o_neg=0.
  - o_ready=1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight beats without producing any output.
- Boundaries:
  - Full-width carry ripple (e.g. all-ones + 1) must propagate across every stage boundary.
  - The carry register of a bubble stage is don't-care, but must not affect valid beats.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ADC, OP_SBB} addsub_op_t.
  - localparam NSTG helper function.
- Sub-module cla_group (combinational, GROUP-bit lookahead group):
  - Inputs a, b, cin.
  - Outputs sum, cout, c_msb_in (carry into the group MSB, used for overflow).
  - Instanced once per stage.
- The top level contains only pipeline registers, skew/de-skew, handshake and flags.

Test Plan:
- Default params; ADD 0x0F+0x01, i_ready=1 -> 2 cycles later o_result=0x10, cout=0, ovf=0, zero=0, neg=0. Verifies inter-group carry.
- SUB 0x80-0x01 -> o_result=0x7F, cout=1, ovf=1. SUB 0x05-0x05 -> 0x00, zero=1, cout=1.
- ADC 0xFF+0x00, i_carry=1 -> 0x00, cout=1, zero=1. SBB 0x10-0x01 with i_carry=1 -> 0x0E, cout=1.
- Back-to-back beats A=0..9, B=1, ADD, with i_ready low for 3 cycles mid-stream:
  - o_ready drops while the output stalls.
  - Results 1..10 arrive in order, none lost or duplicated.
  - Output stays stable during the stall.
- i_reset pulsed with 2 beats in flight -> o_valid stays 0 and the next accepted beat emerges correctly.
- Repeat random add/sub against a reference model for BITS=16, GROUP=4 (latency 4) and BITS=8, GROUP=8 (latency 1).
